// File: rtl/joy_pkg.sv
// Shared joystick constants: frame geometry, tick-to-bit map and reset word.
package joy_pkg;

  localparam int unsigned FRAME_TICKS = 26;
  localparam int unsigned JOY_W       = 12;

  localparam logic [JOY_W-1:0] JOY_RESET_WORD = 12'hFFF;

  localparam int unsigned JOY_BIT_RESET = 11;
  localparam int unsigned JOY_BIT_COIN  = 9;
  localparam int unsigned JOY_BIT_START = 8;

  typedef struct packed {
    logic [JOY_W-1:0] j2;
    logic [JOY_W-1:0] j1;
  } joy_frame_t;

  localparam joy_frame_t JOY_FRAME_RESET = '{j2: JOY_RESET_WORD, j1: JOY_RESET_WORD};

  // Frame-vector index (j1 in [11:0], j2 in [23:12]) captured at a given tick.
  function automatic logic [4:0] tick_to_bit(input logic [4:0] tick);
    logic [4:0] k;
    logic [4:0] base;
    logic [4:0] bidx;
    if (tick < 5'd18) begin
      base = (tick < 5'd10) ? 5'd0 : 5'd12;
      k    = (tick - 5'd2) & 5'd7;
      bidx = (k == 5'd0) ? 5'd8 : 5'd7 - k;
    end else begin
      base = (tick < 5'd22) ? 5'd12 : 5'd0;
      k    = (tick - 5'd18) & 5'd3;
      case (k[1:0])
        2'd0:    bidx = 5'd10;
        2'd1:    bidx = 5'd11;
        2'd2:    bidx = 5'd9;
        default: bidx = 5'd7;
      endcase
    end
    return base + bidx;
  endfunction

endpackage

// File: rtl/joy_serial_reader_if.sv
// Chain pins and debounced joystick words of the serial joystick reader.
interface joy_serial_reader_if;
  import joy_pkg::*;

  logic             joy_data;
  logic             joy_clk;
  logic             joy_load;
  logic [JOY_W-1:0] joystick1;
  logic [JOY_W-1:0] joystick2;
  logic             frame_strobe;
  logic             update;

  modport master (
    input  joy_data,
    output joy_clk, joy_load, joystick1, joystick2, frame_strobe, update
  );

  modport slave (
    output joy_data,
    input  joy_clk, joy_load, joystick1, joystick2, frame_strobe, update
  );
endinterface

// File: rtl/joy_debounce.sv
// Frame-to-frame debounce: loads the output words only after enough identical frames.
module joy_debounce
  import joy_pkg::*;
#(
  parameter int unsigned DEBOUNCE_FRAMES = 2
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             i_frame_strobe,
  input  joy_frame_t       i_frame,
  output logic [JOY_W-1:0] o_joystick1,
  output logic [JOY_W-1:0] o_joystick2,
  output logic             o_update
);

  localparam int unsigned      MW        = 3;
  localparam logic [MW-1:0]    MATCH_MAX = MW'(DEBOUNCE_FRAMES - 1);

  joy_frame_t    r_prev;
  joy_frame_t    r_out;
  logic [MW-1:0] r_match;
  logic          r_update;

  logic [MW-1:0] w_match_nxt;
  logic          w_load;

  always_comb begin
    w_match_nxt = '0;
    if (i_frame == r_prev)
      w_match_nxt = (r_match == MATCH_MAX) ? r_match : r_match + MW'(1);
    w_load = i_frame_strobe && (w_match_nxt == MATCH_MAX) && (i_frame != r_out);
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_prev   <= JOY_FRAME_RESET;
      r_out    <= JOY_FRAME_RESET;
      r_match  <= '0;
      r_update <= 1'b0;
    end else begin
      r_update <= w_load;
      if (i_frame_strobe) begin
        r_prev  <= i_frame;
        r_match <= w_match_nxt;
        if (w_load) r_out <= i_frame;
      end
    end
  end

  assign o_joystick1 = r_out.j1;
  assign o_joystick2 = r_out.j2;
  assign o_update    = r_update;

endmodule

// File: rtl/joy_serial_reader.sv
// Serial joystick front end: drives the PISO chain, assembles 24-bit frames
// and hands each completed frame to the debounce stage.
module joy_serial_reader
  import joy_pkg::*;
#(
  parameter int unsigned CLK_DIV         = 16,
  parameter int unsigned DEBOUNCE_FRAMES = 2
) (
  input  logic                clock,
  input  logic                reset_n,
  joy_serial_reader_if.master joy
);

  localparam int unsigned     PW         = 9;
  localparam logic [PW-1:0]   PRESC_LAST = PW'(2 * CLK_DIV - 1);
  localparam logic [PW-1:0]   PRESC_HALF = PW'(CLK_DIV - 1);
  localparam logic [4:0]      LAST_TICK  = 5'(FRAME_TICKS - 1);

  typedef enum logic [2:0] {
    ST_IDLE, ST_LOAD, ST_SKIP, ST_SHIFT, ST_COMMIT
  } state_t;

  state_t      r_state, w_state_nxt;
  logic [PW-1:0] r_presc;
  logic        r_joy_clk;
  logic        r_joy_load;
  logic        r_frame_strobe;
  logic        r_sync1, r_sync2;
  logic [4:0]  r_bit_cnt, w_cnt_nxt;
  logic [23:0] r_frame;
  logic        w_tick, w_capture, w_commit;

  // joy_clk rises at the end of each full period; the first rise lands 2*CLK_DIV after reset.
  assign w_tick = (r_presc == PRESC_LAST);

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_presc   <= '0;
      r_joy_clk <= 1'b0;
    end else begin
      r_presc <= w_tick ? '0 : r_presc + PW'(1);
      if (w_tick)                    r_joy_clk <= 1'b1;
      else if (r_presc == PRESC_HALF) r_joy_clk <= 1'b0;
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_sync1 <= 1'b1;
      r_sync2 <= 1'b1;
    end else begin
      r_sync1 <= joy.joy_data;
      r_sync2 <= r_sync1;
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_state   <= ST_IDLE;
      r_bit_cnt <= '0;
    end else begin
      r_state   <= w_state_nxt;
      r_bit_cnt <= w_cnt_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_bit_cnt;
    w_capture   = 1'b0;
    w_commit    = 1'b0;
    if (w_tick)
      w_cnt_nxt = (r_state == ST_IDLE || r_bit_cnt == LAST_TICK) ? 5'd0 : r_bit_cnt + 5'd1;
    case (r_state)
      ST_IDLE, ST_LOAD, ST_SKIP, ST_SHIFT: begin
        if (w_tick) begin
          if (w_cnt_nxt == 5'd0)      w_state_nxt = ST_LOAD;
          else if (w_cnt_nxt == 5'd1) w_state_nxt = ST_SKIP;
          else begin
            w_capture   = 1'b1;
            w_state_nxt = (w_cnt_nxt == LAST_TICK) ? ST_COMMIT : ST_SHIFT;
          end
        end
      end
      // Frame complete; idle in SHIFT at bit 25 until the next tick wraps to LOAD.
      ST_COMMIT: begin
        w_commit    = 1'b1;
        w_state_nxt = ST_SHIFT;
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_joy_load     <= 1'b1;
      r_frame_strobe <= 1'b0;
      r_frame        <= '1;
    end else begin
      r_frame_strobe <= w_commit;
      if (w_tick)    r_joy_load <= (w_cnt_nxt != 5'd0);
      if (w_capture) r_frame[tick_to_bit(w_cnt_nxt)] <= r_sync2;
    end
  end

  joy_debounce #(
    .DEBOUNCE_FRAMES (DEBOUNCE_FRAMES)
  ) u_debounce (
    .clock          (clock),
    .reset_n        (reset_n),
    .i_frame_strobe (w_commit),
    .i_frame        (joy_frame_t'(r_frame)),
    .o_joystick1    (joy.joystick1),
    .o_joystick2    (joy.joystick2),
    .o_update       (joy.update)
  );

  assign joy.joy_clk      = r_joy_clk;
  assign joy.joy_load     = r_joy_load;
  assign joy.frame_strobe = r_frame_strobe;

endmodule

// File: tb/tb_joy_serial_reader.sv
// Directed bench: two readers (16/2 and 4/1) fed by behavioural chain models.
module tb_joy_serial_reader;

  logic clock = 1'b0;
  logic rst_n;
  always #5 clock = ~clock;

  joy_serial_reader_if a_if ();
  joy_serial_reader_if b_if ();

  joy_serial_reader #(.CLK_DIV(16), .DEBOUNCE_FRAMES(2)) u_a (
    .clock(clock), .reset_n(rst_n), .joy(a_if));
  joy_serial_reader #(.CLK_DIV(4), .DEBOUNCE_FRAMES(1)) u_b (
    .clock(clock), .reset_n(rst_n), .joy(b_if));

  int n_chk = 0;
  int n_bad = 0;
  int upd_a = 0;
  int upd_b = 0;
  logic [11:0] pre_a_j1;

  // Tick-indexed chain patterns: bit k is the level presented for tick k+2.
  logic [23:0] pat_a = '1;
  logic [23:0] pat_b = '1;

  // Expected {joystick2, joystick1} with only the bit captured at tick k+2 low.
  logic [23:0] map_tbl [24] = '{
    24'hFFF_EFF, 24'hFFF_FBF, 24'hFFF_FDF, 24'hFFF_FEF,
    24'hFFF_FF7, 24'hFFF_FFB, 24'hFFF_FFD, 24'hFFF_FFE,
    24'hEFF_FFF, 24'hFBF_FFF, 24'hFDF_FFF, 24'hFEF_FFF,
    24'hFF7_FFF, 24'hFFB_FFF, 24'hFFD_FFF, 24'hFFE_FFF,
    24'hBFF_FFF, 24'h7FF_FFF, 24'hDFF_FFF, 24'hF7F_FFF,
    24'hFFF_BFF, 24'hFFF_7FF, 24'hFFF_DFF, 24'hFFF_F7F
  };

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h want %h", tag, got, exp);
    end
  endtask

  function automatic logic [23:0] exp_word(input logic [23:0] p);
    logic [23:0] r;
    r = '1;
    for (int k = 0; k < 24; k++)
      if (!p[k]) r = r & map_tbl[k];
    return r;
  endfunction

  // Chain models: latch pattern on the LOAD tick, present next tick's bit after each rise.
  logic a_clk_q = 1'b0, b_clk_q = 1'b0;
  logic a_dat = 1'b1, b_dat = 1'b1;
  int a_tick = 25, b_tick = 25;
  logic [23:0] a_frm = '1, b_frm = '1;

  always @(negedge clock) begin
    if (a_if.joy_clk && !a_clk_q) begin
      if (!a_if.joy_load) begin a_tick = 0; a_frm = pat_a; end
      else if (a_tick < 25) a_tick++;
      a_dat = (a_tick >= 1 && a_tick <= 24) ? a_frm[5'(a_tick - 1)] : 1'b1;
    end
    a_clk_q = a_if.joy_clk;
    a_if.joy_data = a_dat;
    if (a_if.update) upd_a++;
  end

  always @(negedge clock) begin
    if (b_if.joy_clk && !b_clk_q) begin
      if (!b_if.joy_load) begin b_tick = 0; b_frm = pat_b; end
      else if (b_tick < 25) b_tick++;
      b_dat = (b_tick >= 1 && b_tick <= 24) ? b_frm[5'(b_tick - 1)] : 1'b1;
    end
    b_clk_q = b_if.joy_clk;
    b_if.joy_data = b_dat;
    if (b_if.update) upd_b++;
  end

  task automatic wait_strobe(input int which, output int cnt);
    logic seen;
    seen = 1'b0;
    cnt  = 0;
    while (!seen && cnt < 3000) begin
      pre_a_j1 = a_if.joystick1;
      @(negedge clock);
      cnt++;
      seen = (which == 0) ? a_if.frame_strobe : b_if.frame_strobe;
    end
    if (!seen) check_eq("strobe_timeout", 32'(seen), 32'd1);
  endtask

  task automatic wait_load_low(output int cnt);
    cnt = 0;
    while (a_if.joy_load && cnt < 200) begin @(negedge clock); cnt++; end
  endtask

  initial begin
    int n, base, chg, rises;
    logic pclk;
    logic [23:0] p, e, last;

    rst_n = 1'b0;
    repeat (3) @(negedge clock);
    check_eq("rst_jclk",   32'(a_if.joy_clk), 32'd0);
    check_eq("rst_jload",  32'(a_if.joy_load), 32'd1);
    check_eq("rst_j1",     32'(a_if.joystick1), 32'hFFF);
    check_eq("rst_j2",     32'(a_if.joystick2), 32'hFFF);
    check_eq("rst_strobe", 32'(a_if.frame_strobe), 32'd0);
    check_eq("rst_upd",    32'(a_if.update), 32'd0);
    check_eq("rst_b_j1",   32'(b_if.joystick1), 32'hFFF);

    rst_n = 1'b1;
    wait_load_low(n);
    check_eq("load_first_low", 32'(n), 32'd32);
    n = 0;
    while (!a_if.joy_load && n < 200) begin @(negedge clock); n++; end
    check_eq("load_low_len", 32'(n), 32'd32);

    wait_strobe(0, n);
    check_eq("idle_j1", 32'(a_if.joystick1), 32'hFFF);
    wait_strobe(0, n);
    check_eq("idle_j2", 32'(a_if.joystick2), 32'hFFF);
    check_eq("a_period", 32'(n), 32'd832);
    @(negedge clock);
    check_eq("idle_upd_cnt", 32'(upd_a), 32'd0);

    // j1[0] pressed: tick 9 low.
    pat_a = 24'hFFFF7F;
    wait_strobe(0, n);
    check_eq("press_f1_j1", 32'(a_if.joystick1), 32'hFFF);
    wait_strobe(0, n);
    check_eq("press_pre_j1", 32'(pre_a_j1), 32'hFFF);
    check_eq("press_j1", 32'(a_if.joystick1), 32'hFFE);
    check_eq("press_upd_coinc", 32'(a_if.update), 32'd1);
    @(negedge clock);
    check_eq("press_upd_width", 32'(a_if.update), 32'd0);
    check_eq("press_strobe_width", 32'(a_if.frame_strobe), 32'd0);
    check_eq("press_upd_cnt", 32'(upd_a), 32'd1);

    pat_a = '1;
    wait_strobe(0, n);
    wait_strobe(0, n);
    check_eq("rel_j1", 32'(a_if.joystick1), 32'hFFF);
    @(negedge clock);
    check_eq("rel_upd_cnt", 32'(upd_a), 32'd2);

    // Single-frame glitch on j2[11] (tick 19).
    pat_a = 24'hFDFFFF;
    wait_strobe(0, n);
    pat_a = '1;
    wait_strobe(0, n);
    wait_strobe(0, n);
    check_eq("glitch_j2", 32'(a_if.joystick2), 32'hFFF);
    @(negedge clock);
    check_eq("glitch_upd_cnt", 32'(upd_a), 32'd2);

    // j1 = 000, then reset asserted at tick 14 of a later frame.
    pat_a = 24'h0FFF00;
    wait_strobe(0, n);
    wait_strobe(0, n);
    check_eq("zero_j1", 32'(a_if.joystick1), 32'h000);
    check_eq("zero_j2", 32'(a_if.joystick2), 32'hFFF);
    wait_strobe(0, n);
    rises = 0;
    n = 0;
    pclk = a_if.joy_clk;
    while (rises < 15 && n < 2000) begin
      @(negedge clock);
      n++;
      if (a_if.joy_clk && !pclk) rises++;
      pclk = a_if.joy_clk;
    end
    check_eq("tick14_reached", 32'(rises), 32'd15);
    #3 rst_n = 1'b0;
    #1;
    check_eq("mid_rst_j1",     32'(a_if.joystick1), 32'hFFF);
    check_eq("mid_rst_j2",     32'(a_if.joystick2), 32'hFFF);
    check_eq("mid_rst_jload",  32'(a_if.joy_load), 32'd1);
    check_eq("mid_rst_jclk",   32'(a_if.joy_clk), 32'd0);
    check_eq("mid_rst_strobe", 32'(a_if.frame_strobe), 32'd0);
    check_eq("mid_rst_upd",    32'(a_if.update), 32'd0);
    repeat (4) @(negedge clock);
    rst_n = 1'b1;
    wait_load_low(n);
    check_eq("restart_load", 32'(n), 32'd32);
    wait_strobe(0, n);
    check_eq("restart_f1_j1", 32'(a_if.joystick1), 32'hFFF);
    wait_strobe(0, n);
    check_eq("restart_j1", 32'(a_if.joystick1), 32'h000);
    check_eq("restart_j2", 32'(a_if.joystick2), 32'hFFF);

    // Reader B: CLK_DIV=4, no debounce.
    wait_strobe(1, n);
    wait_strobe(1, n);
    check_eq("b_period", 32'(n), 32'd208);
    for (int k = 0; k < 24; k++) begin
      pat_b = ~(24'h1 << k);
      wait_strobe(1, n);
      check_eq($sformatf("map_t%0d", k + 2), 32'({b_if.joystick2, b_if.joystick1}), 32'(map_tbl[k]));
    end

    last = map_tbl[23];
    @(negedge clock);
    base = upd_b;
    chg  = 0;
    p    = pat_b;
    for (int i = 0; i < 20; i++) begin
      if ($urandom_range(0, 2) != 0) p = 24'($urandom);
      pat_b = p;
      wait_strobe(1, n);
      e = exp_word(p);
      check_eq($sformatf("rnd_word%0d", i), 32'({b_if.joystick2, b_if.joystick1}), 32'(e));
      check_eq($sformatf("rnd_upd%0d", i), 32'(b_if.update), 32'(e != last));
      if (e != last) chg++;
      last = e;
    end
    @(negedge clock);
    check_eq("rnd_upd_cnt", 32'(upd_b - base), 32'(chg));

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule
